obi_slave_sram_resp: RTL and testbench
======================================

Name: obi_slave_sram_resp

Overview:
- OBI responder (slave) terminating the OBI master port of the SPI slave bridge; also usable on any RI5CY/CV32E40-style OBI master.
- Serves word accesses from an internal word-addressed memory. Grant wait states and response latency are configurable.
- Supports up to MAX_OUTSTANDING in-order outstanding transactions.
- Used as the bench/system memory target for SPI-to-OBI traffic.

Parameters:
- OBI_ADDR_WIDTH, 32, address width
- OBI_DATA_WIDTH, 32, data width (multiple of 8)
- MEM_DEPTH, 256, number of data words (power of 2, ≥2)
- GNT_WAIT, 0, cycles from req first seen to gnt (0 = same-cycle gnt)
- RESP_LAT, 1, cycles from an entry becoming response-queue head to r_valid (≥1)
- MAX_OUTSTANDING, 2, response queue depth (≥1)

Ports:
- obi_aclk  in  1  clock
- obi_aresetn  in  1  async active-low reset
- obi_slave_req  in  1  request
- obi_slave_gnt  out  1  grant
- obi_slave_addr  in  OBI_ADDR_WIDTH  byte address
- obi_slave_we  in  1  1=write, 0=read
- obi_slave_be  in  OBI_DATA_WIDTH/8  byte enables
- obi_slave_w_data  in  OBI_DATA_WIDTH  write data
- obi_slave_r_valid  out  1  response valid
- obi_slave_r_ready  in  1  response accept
- obi_slave_r_data  out  OBI_DATA_WIDTH  read data (0 for writes)

Behaviour:
- Reset: obi_aresetn is asynchronous, active-low; clock is obi_aclk. On reset, gnt=0, r_valid=0, r_data=0, grant FSM=IDLE, queue empty, counters 0. The memory array is not reset.
- Reset mid-operation: all in-flight and queued responses are dropped. A memory write already committed stays committed.
- Accept: a request is accepted on a rising edge with req && gnt.
- Room: room = (queue count < MAX_OUTSTANDING). The current-cycle pop is not counted, so there is no bypass.
- Grant FSM:
  - IDLE, GNT_WAIT==0: gnt = req && room.
  - IDLE, GNT_WAIT>0: gnt=0. If req, load cnt=GNT_WAIT-1 and go to WAIT.
  - WAIT: if cnt>0, decrement with gnt=0. If cnt==0, gnt=room. Return to IDLE on accept.
  - Net effect: gnt first asserts GNT_WAIT cycles after req is first seen, then holds until room.
  - If req drops while in WAIT (protocol violation), return to IDLE with no accept.
- Address decode: word index = addr[log2(MEM_DEPTH)+1:2]. An access is in range when addr>>2 < MEM_DEPTH. addr[1:0] are ignored.
- Write on accept: each byte i with be[i]=1 is written at the accept edge. Out-of-range writes are dropped but still produce a response.
- Read on accept: mem[index] is captured into the queue entry at the accept edge. Out-of-range reads capture 0.
- Ordering: a read accepted after a write to the same word returns the new data, including back-to-back accepts.
- Queue contents: FIFO of {rdata, err}, depth MAX_OUTSTANDING, responses returned strictly in accept order. Write responses carry rdata=0.
- Latency counter: loaded with RESP_LAT-1 when an entry becomes head, i.e. on accept into an empty queue or on pop with a remaining entry.
  - r_valid=1 when the queue is non-empty and lat==0.
  - RESP_LAT=1: r_valid in the cycle after the accept edge.
- Response hold: r_valid and r_data are held stable until r_valid && r_ready; that edge pops the head.
- Simultaneous accept and pop: count unchanged. The new entry becomes head only if it was the sole remaining entry.
- Full queue: gnt=0, req is held by the master, no state change.

Optional Feature:
- Macro: OBI_SLAVE_ERR_EN.
- When defined:
  - Adds output port obi_slave_err (1 bit, reset 0).
  - The error flag is set for an out-of-range address OR addr[1:0]!=0.
  - An errored write does not modify memory; an errored read returns r_data=0.
  - obi_slave_err is valid only while r_valid=1 and is 0 otherwise.
- When undefined: the port is absent, misaligned addresses are treated as aligned (low bits ignored), and out-of-range handling is as in Behaviour.

Test Plan:
- Write then read, GNT_WAIT=0, RESP_LAT=1:
  - Write addr 0x10, be=4'hF, wdata 0xDEADBEEF → gnt same cycle, r_valid next cycle with r_data=0.
  - Read addr 0x10 → r_valid next cycle, r_data=0xDEADBEEF.
- Partial write:
  - Preload 0x11223344 at 0x20, write be=4'b0101 with wdata 0xAABBCCDD.
  - Read back 0x11BB33DD.
- Wait states, GNT_WAIT=3, RESP_LAT=2: req held from cycle 0 → gnt first high in cycle 3, r_valid first high in cycle 5.
- Backpressure, MAX_OUTSTANDING=2, r_ready=0:
  - Issue 3 reads → only 2 granted, third req sees gnt=0.
  - Raise r_ready → third granted the cycle after the first pop.
  - Responses arrive in order.
- Out-of-range (MEM_DEPTH=256):
  - Write 0x400 then read 0x400 → r_data=0, mem[0] unchanged.
  - With OBI_SLAVE_ERR_EN, err=1 on both responses; read at addr 0x2 also gives err=1.
- Reset mid-operation: assert obi_aresetn=0 with 2 queued responses → r_valid and gnt go low immediately; after release, no stale response appears.

Source files
------------

// File: rtl/obi_slave_sram_resp.sv
// OBI responder backed by a word-addressed SRAM model with configurable grant wait and response latency.
// Define OBI_SLAVE_ERR_EN to add obi_slave_err (flags out-of-range or misaligned accesses).
module obi_slave_sram_resp #(
  parameter int unsigned OBI_ADDR_WIDTH  = 32,
  parameter int unsigned OBI_DATA_WIDTH  = 32,
  parameter int unsigned MEM_DEPTH       = 256,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RESP_LAT        = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                        obi_aclk,
  input  logic                        obi_aresetn,
  input  logic                        obi_slave_req,
  output logic                        obi_slave_gnt,
  input  logic [OBI_ADDR_WIDTH-1:0]   obi_slave_addr,
  input  logic                        obi_slave_we,
  input  logic [OBI_DATA_WIDTH/8-1:0] obi_slave_be,
  input  logic [OBI_DATA_WIDTH-1:0]   obi_slave_w_data,
  output logic                        obi_slave_r_valid,
`ifdef OBI_SLAVE_ERR_EN
  output logic                        obi_slave_err,
`endif
  input  logic                        obi_slave_r_ready,
  output logic [OBI_DATA_WIDTH-1:0]   obi_slave_r_data
);

  localparam int unsigned BE_W   = OBI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(MEM_DEPTH);
  localparam int unsigned PTR_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned GCNT_W = (GNT_WAIT > 1) ? $clog2(GNT_WAIT) : 1;
  localparam int unsigned LAT_W  = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;

  typedef enum logic {G_IDLE, G_WAIT} gnt_state_e;

  gnt_state_e          gnt_state;
  logic [GCNT_W-1:0]   gnt_cnt;
  logic                gnt_c;
  logic                room;
  logic                accept;
  logic                pop;

  logic [OBI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [OBI_DATA_WIDTH-1:0] rdata_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]          wr_ptr;
  logic [PTR_W-1:0]          rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [LAT_W-1:0]          lat;

  logic [IDX_W-1:0]          idx;
  logic                      in_range;
  logic                      bad;
  logic [OBI_DATA_WIDTH-1:0] push_rdata;

  assign room     = count < CNT_W'(MAX_OUTSTANDING);
  assign accept   = obi_slave_req && obi_slave_gnt;
  assign pop      = obi_slave_r_valid && obi_slave_r_ready;
  assign idx      = obi_slave_addr[IDX_W+1:2];
  assign in_range = (obi_slave_addr >> (IDX_W + 2)) == '0;

`ifdef OBI_SLAVE_ERR_EN
  logic err_q [MAX_OUTSTANDING];
  assign bad = !in_range || (obi_slave_addr[1:0] != 2'b00);
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^obi_slave_addr[1:0];
  assign bad = !in_range;
`endif

  assign push_rdata = (obi_slave_we || bad) ? '0 : mem[idx];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Grant is combinational so a zero-wait slave can grant in the request cycle; held low in reset.
  always_comb begin
    gnt_c = 1'b0;
    if (GNT_WAIT == 0) begin
      gnt_c = obi_slave_req && room;
    end else if (gnt_state == G_WAIT && gnt_cnt == '0) begin
      gnt_c = room;
    end
  end

  assign obi_slave_gnt = obi_aresetn && gnt_c;

  always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
    if (!obi_aresetn) begin
      gnt_state <= G_IDLE;
      gnt_cnt   <= '0;
    end else if (GNT_WAIT != 0) begin
      case (gnt_state)
        G_IDLE: begin
          if (obi_slave_req) begin
            gnt_cnt   <= GCNT_W'(GNT_WAIT - 1);
            gnt_state <= G_WAIT;
          end
        end
        G_WAIT: begin
          if (!obi_slave_req) begin
            gnt_state <= G_IDLE;
          end else if (gnt_cnt != '0) begin
            gnt_cnt <= gnt_cnt - GCNT_W'(1);
          end else if (accept) begin
            gnt_state <= G_IDLE;
          end
        end
        default: gnt_state <= G_IDLE;
      endcase
    end
  end

  // Response queue control; latency restarts whenever a new entry reaches the head.
  always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
    if (!obi_aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      lat    <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_next(wr_ptr);
      if (pop)    rd_ptr <= ptr_next(rd_ptr);
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if ((accept && count == '0) || (pop && (count > CNT_W'(1) || accept))) begin
        lat <= LAT_W'(RESP_LAT - 1);
      end else if (count != '0 && lat != '0) begin
        lat <= lat - LAT_W'(1);
      end
    end
  end

  always_ff @(posedge obi_aclk) begin
    if (accept) begin
      rdata_q[wr_ptr] <= push_rdata;
`ifdef OBI_SLAVE_ERR_EN
      err_q[wr_ptr]   <= bad;
`endif
    end
  end

  // Byte-masked write at the accept edge; a following read sees it through the array.
  always_ff @(posedge obi_aclk) begin
    if (accept && obi_slave_we && !bad) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (obi_slave_be[i]) mem[idx][i*8 +: 8] <= obi_slave_w_data[i*8 +: 8];
      end
    end
  end

  assign obi_slave_r_valid = (count != '0) && (lat == '0);
  assign obi_slave_r_data  = obi_slave_r_valid ? rdata_q[rd_ptr] : '0;
`ifdef OBI_SLAVE_ERR_EN
  assign obi_slave_err     = obi_slave_r_valid && err_q[rd_ptr];
`endif

endmodule

// File: tb/tb_obi_slave_sram_resp.sv
// Scoreboard bench for obi_slave_sram_resp: a zero-wait instance with a response monitor, plus a wait-state instance.
module tb_obi_slave_sram_resp;

`ifdef OBI_SLAVE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req, gnt, we, r_valid, r_ready;
  logic [31:0] addr, wdata, r_data;
  logic [3:0]  be;
  logic        req1, gnt1, we1, r_valid1, r_ready1;
  logic [31:0] addr1, wdata1, r_data1;
  logic [3:0]  be1;
`ifdef OBI_SLAVE_ERR_EN
  logic        err, err1;
`endif

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  obi_slave_sram_resp #(
    .OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .MEM_DEPTH(256),
    .GNT_WAIT(0), .RESP_LAT(1), .MAX_OUTSTANDING(2)
  ) dut0 (
    .obi_aclk(clk), .obi_aresetn(rst_n),
    .obi_slave_req(req), .obi_slave_gnt(gnt), .obi_slave_addr(addr),
    .obi_slave_we(we), .obi_slave_be(be), .obi_slave_w_data(wdata),
    .obi_slave_r_valid(r_valid),
`ifdef OBI_SLAVE_ERR_EN
    .obi_slave_err(err),
`endif
    .obi_slave_r_ready(r_ready), .obi_slave_r_data(r_data)
  );

  obi_slave_sram_resp #(
    .OBI_ADDR_WIDTH(32), .OBI_DATA_WIDTH(32), .MEM_DEPTH(256),
    .GNT_WAIT(3), .RESP_LAT(2), .MAX_OUTSTANDING(2)
  ) dut1 (
    .obi_aclk(clk), .obi_aresetn(rst_n),
    .obi_slave_req(req1), .obi_slave_gnt(gnt1), .obi_slave_addr(addr1),
    .obi_slave_we(we1), .obi_slave_be(be1), .obi_slave_w_data(wdata1),
    .obi_slave_r_valid(r_valid1),
`ifdef OBI_SLAVE_ERR_EN
    .obi_slave_err(err1),
`endif
    .obi_slave_r_ready(r_ready1), .obi_slave_r_data(r_data1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every completed response handshake is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && r_valid && r_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL resp_unexpected: got r_data 0x%08h expected no response", r_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("resp_rdata", r_data, e.rdata);
`ifdef OBI_SLAVE_ERR_EN
        check("resp_err", {31'b0, err}, {31'b0, e.err});
`endif
      end
    end
  end

  // Drive one request on dut0 (from posedge+1), wait for gnt, record expectation; returns at posedge+1 after accept.
  task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err, output int waited);
    exp_t e;
    int   n;
    req = 1'b1; we = w; addr = a; be = b; wdata = d;
    n = 0;
    @(negedge clk);
    while (!gnt && n < 50) begin
      @(negedge clk);
      n++;
    end
    waited = n;
    if (!gnt) begin
      checks++;
      errors++;
      $display("FAIL gnt_timeout: no gnt for addr 0x%08h within 50 cycles", a);
    end else begin
      e.rdata = exp_rd;
      e.err   = exp_err;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  // Wait-state instance: req held from cycle 0, measure first gnt and first r_valid cycles.
  task automatic wait_test(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] exp_rd);
    int first_gnt;
    int first_rv;
    first_gnt = -1;
    first_rv  = -1;
    req1 = 1'b1; we1 = w; addr1 = a; be1 = 4'hF; wdata1 = d;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (gnt1 && first_gnt < 0) first_gnt = c;
      if (r_valid1 && first_rv < 0) begin
        first_rv = c;
        check("wait_rdata", r_data1, exp_rd);
      end
      @(posedge clk); #1;
      if (first_gnt >= 0) req1 = 1'b0;
    end
    req1 = 1'b0;
    check("wait_first_gnt_cycle", 32'(first_gnt), 32'd3);
    check("wait_first_rvalid_cycle", 32'(first_rv), 32'd5);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; be = '0; wdata = '0; r_ready = 1'b1;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0; r_ready1 = 1'b1;

    // Reset state, including gnt held low while req is asserted in reset
    #2 req = 1'b1; req1 = 1'b1;
    #1;
    check("reset_gnt", {31'b0, gnt}, 32'd0);
    check("reset_rvalid", {31'b0, r_valid}, 32'd0);
    check("reset_rdata", r_data, 32'd0);
    check("reset_gnt1", {31'b0, gnt1}, 32'd0);
    check("reset_rvalid1", {31'b0, r_valid1}, 32'd0);
    req = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Wait states and response latency (GNT_WAIT=3, RESP_LAT=2)
    wait_test(1'b1, 32'h4, 32'h1234_5678, 32'h0);
    wait_test(1'b0, 32'h4, 32'h0, 32'h1234_5678);

    // Write then read with same-cycle grant and one-cycle response
    issue(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0, w);
    check("write_gnt_wait", 32'(w), 32'd0);
    req = 1'b0;
    @(negedge clk);
    check("write_lat1_rvalid", {31'b0, r_valid}, 32'd1);
    check("write_lat1_rdata", r_data, 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    req = 1'b0;
    @(negedge clk);
    check("read_lat1_rvalid", {31'b0, r_valid}, 32'd1);
    check("read_lat1_rdata", r_data, 32'hDEAD_BEEF);
    @(posedge clk); #1;

    // Partial write, back-to-back with the read that must observe it
    issue(1'b1, 32'h20, 4'hF, 32'h1122_3344, 32'h0, 1'b0, w);
    issue(1'b1, 32'h20, 4'b0101, 32'hAABB_CCDD, 32'h0, 1'b0, w);
    issue(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, w);

    // Out-of-range must not alias onto word 0; misaligned read
    issue(1'b1, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0, w);
    issue(1'b1, 32'h400, 4'hF, 32'h5555_5555, 32'h0, ERR_ON, w);
    issue(1'b0, 32'h400, 4'hF, 32'h0, 32'h0, ERR_ON, w);
    issue(1'b0, 32'h0, 4'hF, 32'h0, 32'hCAFE_F00D, 1'b0, w);
    issue(1'b0, 32'h12, 4'hF, 32'h0, ERR_ON ? 32'h0 : 32'hDEAD_BEEF, ERR_ON, w);
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: queue of 2 fills, third request waits for a pop, no bypass
    r_ready = 1'b0;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    issue(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, w);
    req = 1'b1; we = 1'b0; addr = 32'h0; be = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_gnt_low", {31'b0, gnt}, 32'd0);
      check("full_rvalid_held", {31'b0, r_valid}, 32'd1);
      check("full_rdata_held", r_data, 32'hDEAD_BEEF);
      @(posedge clk); #1;
    end
    r_ready = 1'b1;
    @(negedge clk);
    check("pop_cycle_gnt_no_bypass", {31'b0, gnt}, 32'd0);
    @(negedge clk);
    check("gnt_after_pop", {31'b0, gnt}, 32'd1);
    if (gnt) begin
      exp_t e;
      e.rdata = 32'hCAFE_F00D;
      e.err   = 1'b0;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("bp_drained", 32'(exp_q.size()), 32'd0);

    // Reset with two queued responses: outputs drop at once, nothing stale afterwards
    r_ready = 1'b0;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    issue(1'b0, 32'h20, 4'hF, 32'h0, 32'h11BB_33DD, 1'b0, w);
    req = 1'b1; addr = 32'h0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rvalid", {31'b0, r_valid}, 32'd0);
    check("midrst_gnt", {31'b0, gnt}, 32'd0);
    check("midrst_rdata", r_data, 32'd0);
    exp_q.delete();
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    r_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("post_rst_no_stale", {31'b0, r_valid}, 32'd0);
    @(posedge clk); #1;
    issue(1'b0, 32'h10, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b0, w);
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
